// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the single-memory RV32I datapath.
// Steps each instruction through FETCH/RD1/RD2/EXEC/MEM/WB and traps illegal opcodes.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        brEq,
   input  logic        brLt,
   input  logic        brLtu,
   output logic        fetchEn,
   output logic [1:0]  regSel,
   output logic        rs1En,
   output logic        rs2En,
   output logic        regWEn,
   output logic [2:0]  immCtrl,
   output logic        immEn,
   output logic [1:0]  srcASel,
   output logic        srcBSel,
   output logic [3:0]  aluCtrl,
   output logic        aluEn,
   output logic        pcEn,
   output logic        jalEn,
   output logic        branch,
   output logic        wEn,
   output logic [1:0]  byteSel,
   output logic        zeroSigned,
   output logic        wbEn,
   output logic [1:0]  wbSel,
   output logic        halted
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   typedef enum logic [2:0] {
      S_FETCH,
      S_RD1,
      S_RD2,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   state_t state;
   logic   taken;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rd;
   logic       alt_bit;
   logic       is_op, is_opimm, is_load, is_store, is_branch;
   logic       is_jal, is_jalr, is_lui, is_auipc;
   logic       needs_rs2, single_read;
   logic       unused_instr_bits;

   assign opcode  = instr[6:0];
   assign rd      = instr[11:7];
   assign funct3  = instr[14:12];
   assign alt_bit = instr[30];
   assign unused_instr_bits = ^{instr[31], instr[29:15]};

   assign is_op     = (opcode == OPC_OP);
   assign is_opimm  = (opcode == OPC_OPIMM);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_lui    = (opcode == OPC_LUI);
   assign is_auipc  = (opcode == OPC_AUIPC);

   // The single register port means anything needing rs2 costs an extra read cycle.
   assign needs_rs2   = is_op | is_store | is_branch;
   assign single_read = is_opimm | is_load | is_jalr | is_jal | is_lui | is_auipc;

   function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt,
                                         input logic reg_form);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (reg_form && alt) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic logic [2:0] imm_fmt(input logic [6:0] opc);
      logic [2:0] fmt;
      case (opc)
         OPC_STORE:          fmt = IMM_S;
         OPC_BRANCH:         fmt = IMM_B;
         OPC_LUI, OPC_AUIPC: fmt = IMM_U;
         OPC_JAL:            fmt = IMM_J;
         default:            fmt = IMM_I;
      endcase
      return fmt;
   endfunction

   // funct3 size code (00 byte, 01 half, 1x word) to the extender's select.
   function automatic logic [1:0] size_sel(input logic [1:0] sz);
      logic [1:0] sel;
      case (sz)
         2'b00:   sel = 2'd2;
         2'b01:   sel = 2'd1;
         default: sel = 2'd0;
      endcase
      return sel;
   endfunction

   function automatic logic branch_cond(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic ltu);
      logic t;
      case (f3)
         3'b000:  t = eq;
         3'b001:  t = ~eq;
         3'b100:  t = lt;
         3'b101:  t = ~lt;
         3'b110:  t = ltu;
         3'b111:  t = ~ltu;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         taken <= 1'b0;
      end else begin
         case (state)
            S_FETCH: state <= S_RD1;
            S_RD1: begin
               if (needs_rs2)
                  state <= S_RD2;
               else if (single_read)
                  state <= S_EXEC;
               else
                  state <= S_TRAP;
            end
            S_RD2:   state <= S_EXEC;
            S_EXEC: begin
               if (is_branch)
                  taken <= branch_cond(funct3, brEq, brLt, brLtu);
               state <= (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM:   state <= is_load ? S_WB : S_FETCH;
            S_WB:    state <= S_FETCH;
            S_TRAP:  state <= S_TRAP;
            default: state <= S_FETCH;
         endcase
      end
   end

   // Outputs decode from state and instr; reset forces everything low in the same cycle
   // so no write, store or PC update can complete under reset.
   always_comb begin
      fetchEn    = 1'b0;
      regSel     = 2'd0;
      rs1En      = 1'b0;
      rs2En      = 1'b0;
      regWEn     = 1'b0;
      immCtrl    = IMM_I;
      immEn      = 1'b0;
      srcASel    = 2'd0;
      srcBSel    = 1'b0;
      aluCtrl    = ALU_ADD;
      aluEn      = 1'b0;
      pcEn       = 1'b0;
      jalEn      = 1'b0;
      branch     = 1'b0;
      wEn        = 1'b0;
      byteSel    = 2'd0;
      zeroSigned = 1'b0;
      wbEn       = 1'b0;
      wbSel      = 2'd0;
      halted     = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: fetchEn = 1'b1;
            S_RD1: begin
               regSel  = 2'd0;
               rs1En   = 1'b1;
               immEn   = 1'b1;
               immCtrl = imm_fmt(opcode);
            end
            S_RD2: begin
               regSel = 2'd2;
               rs2En  = 1'b1;
            end
            S_EXEC: begin
               aluEn   = 1'b1;
               aluCtrl = (is_op || is_opimm) ? alu_op(funct3, alt_bit, is_op) : ALU_ADD;
               if (is_lui)
                  srcASel = 2'd2;
               else if (is_auipc || is_jal || is_branch)
                  srcASel = 2'd1;
               else
                  srcASel = 2'd0;
               srcBSel = ~is_op;
            end
            S_MEM: begin
               byteSel    = size_sel(funct3[1:0]);
               zeroSigned = ~funct3[2];
               wbEn       = is_load;
               wEn        = is_store;
               pcEn       = is_store;
            end
            S_WB: begin
               regSel = 2'd1;
               pcEn   = 1'b1;
               regWEn = (rd != 5'd0) && !is_branch;
               if (is_load)
                  wbSel = 2'd2;
               else if (is_jal || is_jalr)
                  wbSel = 2'd0;
               else
                  wbSel = 2'd1;
               jalEn  = is_jal | is_jalr;
               branch = is_branch & taken;
            end
            S_TRAP:  halted = 1'b1;
            default: halted = 1'b0;
         endcase
      end
   end

endmodule
